sort_oet_engine: RTL and testbench
==================================

// Module: sort_oet_engine
// PURPOSE
//  Parametrised iterative odd-even transposition sorter; successor to the fixed 8x32 sorting_8.
//  Accepts one vector of N unsigned W-bit keys per valid/ready handshake and sorts it in place,
//  one compare-exchange phase per clock. Sort order is selectable per vector.
//  Exits early once the vector is sorted, then presents the result with a valid/ready handshake.
// PARAMETERS
//  N  8   number of keys, N >= 2 (odd N allowed)
//  W  32  key width in bits, W >= 1
//  CW $clog2(N+1)  phase-count width (localparam, not overridable)
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      input vector valid
//  in_ready    out  1      engine can accept a vector
//  in_data     in   N*W    key i at [i*W +: W]
//  in_descend  in   1      0 = ascending (key 0 smallest), 1 = descending; sampled with in_data
//  out_valid   out  1      sorted vector valid
//  out_ready   in   1      downstream accepts the result
//  out_data    out  N*W    sorted keys, same packing as in_data
//  out_phases  out  CW     number of phases executed for this vector
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, out_data=0, out_phases=0, internal phase/count/flags cleared.
//   in_ready=1 one delta after reset asserts (decoded from state).
//  States: IDLE -> SORT -> DONE -> IDLE.
//  IDLE: in_ready=1. in_valid&in_ready on edge E0 captures in_data and in_descend, phase=even,
//   cnt=0, go SORT. in_ready=0 in SORT and DONE; in_valid there is ignored (no overlap).
//  SORT: each edge applies one phase to the working vector:
//   even phase pairs (0,1),(2,3)..; odd phase pairs (1,2),(3,4)..; unpaired end key passes through.
//   Asc: swap if key[j] > key[j+1]. Desc: swap if key[j] < key[j+1]. Unsigned compare.
//   Equal keys never swap and never count as a swap.
//   Phase alternates every edge; cnt increments per phase.
//  SORT exit: on the edge completing phase k, go DONE when cnt reaches N, or when phase k and
//   phase k-1 both performed zero swaps. Hence 2 <= k <= N.
//  DONE: out_valid=1; out_data=sorted vector; out_phases=k. All outputs held stable until
//   out_valid&out_ready, then IDLE with out_valid=0 on that edge; out_data/out_phases keep
//   the last values. Fastest re-accept is the edge after the result handshake.
//  Latency: vector accepted at E0; out_valid is high after edge E0+k (k cycles busy).
//  N=2: odd phase has no pairs, so k is always 2.
//  rst asserted at any time (mid-SORT, in DONE) aborts immediately: partial data discarded,
//   out_valid drops asynchronously, no result emitted.
//  in_descend is latched at E0; changes during SORT/DONE have no effect.
// STRUCTURE
//  Package sort_pkg: state enum {IDLE,SORT,DONE} (2-bit encoding), phase parity constants.
//   This package is shared with future sort blocks.
//  Sub-module cmp_swap #(W): combinational; inputs a, b, descend; outputs lo, hi, swapped.
//   Instantiated floor(N/2) times for even pairs and floor((N-1)/2) times for odd pairs.
//  Top: FSM, working register array, phase counter, two-deep zero-swap history, output registers.
// TESTING
//  1 N=8,W=32,asc; in 11,90,43,70,30,44,40,32 -> out 11,30,32,40,43,44,70,90; out_phases<=8
//  2 Same input, in_descend=1 -> out 90,70,44,43,40,32,30,11
//  3 Already sorted 1..8 asc -> out 1..8, out_phases=2, out_valid exactly 2 cycles after accept
//  4 Reversed 8..1 asc -> out 1..8, out_phases=8; dups 5,5,3,3,9,9,0,0 -> 0,0,3,3,5,5,9,9
//  5 out_ready low 5 cycles in DONE: data stable, in_ready=0, in_valid ignored; then back-to-back vector
//  6 rst mid-SORT (cycle 3): out_valid=0, in_ready=1 after release; next vector sorts correctly.
//    Repeat scenarios 1 and 3 with N=2,W=8 and with N=5,W=4 (wrap-free max 15).

Source files
------------

// File: rtl/sort_oet_engine_pkg.sv
// Shared definitions for the sort engine family: FSM state encoding and phase parity.
package sort_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic PH_EVEN = 1'b0;
  localparam logic PH_ODD  = 1'b1;
endpackage

// File: rtl/sort_oet_engine_if.sv
// Input/output stream bundle for sort_oet_engine; master drives vectors, slave is the engine.
interface sort_oet_engine_if #(
  parameter int N = 8,
  parameter int W = 32
);
  localparam int CW = $clog2(N + 1);

  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           in_descend;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic [CW-1:0]  out_phases;

  modport master (
    output in_valid, in_data, in_descend, out_ready,
    input  in_ready, out_valid, out_data, out_phases
  );

  modport slave (
    input  in_valid, in_data, in_descend, out_ready,
    output in_ready, out_valid, out_data, out_phases
  );
endinterface

// File: rtl/sort_oet_engine_cmp_swap.sv
// Single compare-exchange cell: lo/hi are the keys for positions j and j+1 after the phase.
module cmp_swap #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         descend,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);
  // Strict compares so equal keys stay put and never report a swap.
  always_comb begin
    swapped = descend ? (a < b) : (a > b);
    lo      = swapped ? b : a;
    hi      = swapped ? a : b;
  end
endmodule

// File: rtl/sort_oet_engine.sv
// Iterative odd-even transposition sorter: one compare-exchange phase per clock, early exit
// after two consecutive swap-free phases, result held until the downstream handshake.
module sort_oet_engine
  import sort_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  sort_oet_engine_if.slave    bus
);
  localparam int CW  = $clog2(N + 1);
  localparam int NE  = N / 2;
  localparam int NO  = (N - 1) / 2;
  localparam int NOW = (NO > 0) ? NO : 1;

  state_t         state;
  logic           phase;
  logic [CW-1:0]  cnt;
  logic           zero_prev;
  logic           desc_q;
  logic [W-1:0]   work   [N];
  logic [W-1:0]   even_v [N];
  logic [W-1:0]   odd_v  [N];
  logic [W-1:0]   next_v [N];
  logic [NE-1:0]  ev_sw;
  logic [NOW-1:0] od_sw;
  logic           any_swap;
  logic           last_phase;
  logic           out_valid_q;
  logic [N*W-1:0] out_data_q;
  logic [CW-1:0]  out_phases_q;

  for (genvar i = 0; i < NE; i++) begin : g_even
    cmp_swap #(.W(W)) u_cs (
      .a(work[2*i]), .b(work[2*i+1]), .descend(desc_q),
      .lo(even_v[2*i]), .hi(even_v[2*i+1]), .swapped(ev_sw[i])
    );
  end
  if (N % 2 == 1) begin : g_even_tail
    assign even_v[N-1] = work[N-1];
  end

  // Odd phase: key 0 always passes through, and the last key too when N is even.
  assign odd_v[0] = work[0];
  for (genvar i = 0; i < NO; i++) begin : g_odd
    cmp_swap #(.W(W)) u_cs (
      .a(work[2*i+1]), .b(work[2*i+2]), .descend(desc_q),
      .lo(odd_v[2*i+1]), .hi(odd_v[2*i+2]), .swapped(od_sw[i])
    );
  end
  if (N % 2 == 0) begin : g_odd_tail
    assign odd_v[N-1] = work[N-1];
  end
  if (NO == 0) begin : g_odd_none
    assign od_sw = '0;
  end

  always_comb begin
    any_swap = (phase == PH_EVEN) ? |ev_sw : |od_sw;
    for (int i = 0; i < N; i++) next_v[i] = (phase == PH_EVEN) ? even_v[i] : odd_v[i];
    last_phase = (cnt == CW'(N - 1)) || (!any_swap && zero_prev);
  end

  // Working vector: loaded on accept, rewritten every SORT cycle; reset only affects control.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      for (int i = 0; i < N; i++) work[i] <= bus.in_data[i*W +: W];
    end else if (state == SORT) begin
      for (int i = 0; i < N; i++) work[i] <= next_v[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= PH_EVEN;
      cnt          <= '0;
      zero_prev    <= 1'b0;
      desc_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_phases_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            desc_q    <= bus.in_descend;
            phase     <= PH_EVEN;
            cnt       <= '0;
            zero_prev <= 1'b0;
            state     <= SORT;
          end
        end
        SORT: begin
          phase     <= ~phase;
          cnt       <= cnt + CW'(1);
          zero_prev <= ~any_swap;
          if (last_phase) begin
            state        <= DONE;
            out_valid_q  <= 1'b1;
            out_phases_q <= cnt + CW'(1);
            for (int i = 0; i < N; i++) out_data_q[i*W +: W] <= next_v[i];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_phases = out_phases_q;
endmodule

// File: tb/tb_sort_oet_engine.sv
// Bench for sort_oet_engine: three configurations (8x32, 2x8, 5x4) checked against a queue sort
// and an array-level odd-even transposition phase model.
module tb_sort_oet_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv   [3];
  logic         desc [3];
  logic         ordy [3];
  logic [255:0] din  [3];
  logic         ir   [3];
  logic         ov   [3];
  logic [255:0] dout [3];
  logic [7:0]   ph   [3];

  int errors = 0;
  int checks = 0;

  sort_oet_engine_if #(.N(8), .W(32)) if8 ();
  sort_oet_engine_if #(.N(2), .W(8))  if2 ();
  sort_oet_engine_if #(.N(5), .W(4))  if5 ();

  sort_oet_engine #(.N(8), .W(32)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
  sort_oet_engine #(.N(2), .W(8))  u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  sort_oet_engine #(.N(5), .W(4))  u_dut5 (.clk(clk), .rst(rst), .bus(if5));

  assign if8.in_valid = iv[0];   assign if8.in_descend = desc[0];
  assign if8.out_ready = ordy[0]; assign if8.in_data = din[0][255:0];
  assign if2.in_valid = iv[1];   assign if2.in_descend = desc[1];
  assign if2.out_ready = ordy[1]; assign if2.in_data = din[1][15:0];
  assign if5.in_valid = iv[2];   assign if5.in_descend = desc[2];
  assign if5.out_ready = ordy[2]; assign if5.in_data = din[2][19:0];

  assign ir[0] = if8.in_ready; assign ov[0] = if8.out_valid;
  assign dout[0] = 256'(if8.out_data); assign ph[0] = 8'(if8.out_phases);
  assign ir[1] = if2.in_ready; assign ov[1] = if2.out_valid;
  assign dout[1] = 256'(if2.out_data); assign ph[1] = 8'(if2.out_phases);
  assign ir[2] = if5.in_ready; assign ov[2] = if5.out_valid;
  assign dout[2] = 256'(if5.out_data); assign ph[2] = 8'(if5.out_phases);

  function automatic int n_of(input int s);
    case (s)
      0: return 8;
      1: return 2;
      default: return 5;
    endcase
  endfunction

  function automatic int w_of(input int s);
    case (s)
      0: return 32;
      1: return 8;
      default: return 4;
    endcase
  endfunction

  // Number of phases the algorithm runs: phases alternate even/odd, stop at n phases or
  // after two consecutive phases with no swap.
  function automatic int model_phases(input int n, input bit d, input int unsigned keys[8]);
    int unsigned a[8];
    int unsigned t;
    int k = 0;
    int sw;
    bit prev_zero = 1'b0;
    bit fin = 1'b0;
    a = keys;
    while (!fin) begin
      sw = 0;
      for (int j = k % 2; j + 1 < n; j += 2) begin
        if (d ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t; sw++;
        end
      end
      k++;
      if (k == n) fin = 1'b1;
      else if (k >= 2 && sw == 0 && prev_zero) fin = 1'b1;
      prev_zero = (sw == 0);
    end
    return k;
  endfunction

  task automatic run_vec(input int s, input int unsigned keys_in[8], input bit d,
                         input int exp_k, input int hold, input string nm);
    int n, w, k, lat;
    longint unsigned mask, got;
    int unsigned keys[8];
    int unsigned q[$];
    logic [255:0] pk, snap;
    n = n_of(s); w = w_of(s);
    mask = (64'd1 << w) - 64'd1;
    pk = '0;
    for (int i = 0; i < 8; i++) begin
      keys[i] = (i < n) ? int'(longint'(keys_in[i]) & mask) : 0;
      if (i < n) pk |= 256'(keys[i]) << (i * w);
    end
    k = model_phases(n, d, keys);
    lat = 0;
    while (!ir[s] && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (ir[s] !== 1'b1) begin
      errors++; $display("FAIL %s: in_ready got %b required 1 (timeout)", nm, ir[s]); return;
    end
    din[s] = pk; desc[s] = d; iv[s] = 1'b1;
    @(posedge clk); #1;
    iv[s] = 1'b0; desc[s] = ~d; din[s] = ~pk;
    lat = 0;
    while (!ov[s] && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== k) begin
      errors++; $display("FAIL %s: latency got %0d required %0d", nm, lat, k);
      if (!ov[s]) return;
    end
    checks++;
    if (ph[s] !== 8'(k)) begin
      errors++; $display("FAIL %s: out_phases got %0d required %0d", nm, ph[s], k);
    end
    if (exp_k >= 0) begin
      checks++;
      if (ph[s] !== 8'(exp_k)) begin
        errors++; $display("FAIL %s: out_phases got %0d required fixed %0d", nm, ph[s], exp_k);
      end
    end
    for (int i = 0; i < n; i++) q.push_back(keys[i]);
    if (d) q.rsort(); else q.sort();
    for (int i = 0; i < n; i++) begin
      got = 64'((dout[s] >> (i * w)) & 256'(mask));
      checks++;
      if (got !== longint'(q[i])) begin
        errors++; $display("FAIL %s: key[%0d] got %0d required %0d", nm, i, got, q[i]);
      end
    end
    snap = dout[s];
    for (int h = 0; h < hold; h++) begin
      iv[s] = 1'b1; din[s] = {8{$urandom}}; desc[s] = $urandom_range(0, 1);
      @(posedge clk); #1;
      checks++;
      if (ov[s] !== 1'b1 || ir[s] !== 1'b0 || dout[s] !== snap) begin
        errors++;
        $display("FAIL %s: hold cycle %0d out_valid=%b in_ready=%b data_stable=%b required 1,0,1",
                 nm, h, ov[s], ir[s], dout[s] === snap);
      end
    end
    iv[s] = 1'b0;
    ordy[s] = 1'b1;
    @(posedge clk); #1;
    ordy[s] = 1'b0;
    checks++;
    if (ov[s] !== 1'b0 || ir[s] !== 1'b1 || dout[s] !== snap) begin
      errors++;
      $display("FAIL %s: after handshake out_valid=%b in_ready=%b data_kept=%b required 0,1,1",
               nm, ov[s], ir[s], dout[s] === snap);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      iv[s] = 1'b0; desc[s] = 1'b0; ordy[s] = 1'b0; din[s] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (ov[s] !== 1'b0 || ir[s] !== 1'b1 || dout[s] !== '0 || ph[s] !== 8'd0) begin
        errors++;
        $display("FAIL reset[%0d]: out_valid=%b in_ready=%b out_data=%0h out_phases=%0d required 0,1,0,0",
                 s, ov[s], ir[s], dout[s], ph[s]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (ov[s] !== 1'b0 || ir[s] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release[%0d]: out_valid=%b in_ready=%b required 0,1", s, ov[s], ir[s]);
      end
    end
  endtask

  task automatic test_basic();
    run_vec(0, '{11, 90, 43, 70, 30, 44, 40, 32}, 1'b0, -1, 0, "asc8");
    run_vec(0, '{11, 90, 43, 70, 30, 44, 40, 32}, 1'b1, -1, 0, "desc8");
  endtask

  task automatic test_early_exit();
    run_vec(0, '{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0, 2, 0, "sorted8");
    run_vec(0, '{8, 7, 6, 5, 4, 3, 2, 1}, 1'b0, 8, 0, "reversed8");
    run_vec(0, '{5, 5, 3, 3, 9, 9, 0, 0}, 1'b0, -1, 0, "dups8");
    run_vec(0, '{7, 7, 7, 7, 7, 7, 7, 7}, 1'b1, 2, 0, "equal8");
  endtask

  task automatic test_back_to_back();
    run_vec(0, '{4, 1, 3, 2, 8, 6, 7, 5}, 1'b0, -1, 5, "hold8");
    run_vec(0, '{32'hFFFF_FFFF, 0, 32'h8000_0000, 1, 2, 3, 4, 5}, 1'b1, -1, 0, "b2b8");
  endtask

  task automatic test_reset_mid();
    int unsigned ks[8];
    din[0] = '0;
    for (int i = 0; i < 8; i++) din[0] |= 256'(8 - i) << (i * 32);
    desc[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      errors++; $display("FAIL reset_mid: out_valid=%b in_ready=%b required 0,1", ov[0], ir[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_idle: cycle %0d out_valid=%b in_ready=%b required 0,1", c, ov[0], ir[0]);
      end
    end
    for (int i = 0; i < 8; i++) ks[i] = $urandom;
    run_vec(0, ks, 1'b0, -1, 0, "after_reset8");
  endtask

  task automatic test_small();
    run_vec(1, '{200, 17, 0, 0, 0, 0, 0, 0}, 1'b0, 2, 0, "asc2");
    run_vec(1, '{1, 2, 0, 0, 0, 0, 0, 0}, 1'b0, 2, 0, "sorted2");
    run_vec(1, '{3, 250, 0, 0, 0, 0, 0, 0}, 1'b1, 2, 0, "desc2");
    run_vec(2, '{11, 9, 4, 15, 0, 0, 0, 0}, 1'b0, -1, 0, "asc5");
    run_vec(2, '{1, 2, 3, 4, 5, 0, 0, 0}, 1'b0, 2, 0, "sorted5");
    run_vec(2, '{5, 4, 3, 2, 1, 0, 0, 0}, 1'b0, 5, 0, "reversed5");
    run_vec(2, '{11, 9, 4, 15, 0, 0, 0, 0}, 1'b1, -1, 2, "desc5");
  endtask

  task automatic test_random();
    int unsigned ks[8];
    for (int it = 0; it < 10; it++) begin
      for (int s = 0; s < 3; s++) begin
        for (int i = 0; i < 8; i++) ks[i] = (it % 3 == 0) ? $urandom_range(0, 3) : $urandom;
        run_vec(s, ks, 1'($urandom_range(0, 1)), -1, 0, "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_exit();
    test_back_to_back();
    test_reset_mid();
    test_small();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
